conv_maxpool2: RTL

Downstream stage of the two-kernel convolution block. Consumes the signed fixed-point result stream (data_o/valid_o) of the convolution and performs 2×2, stride-2 max pooling on the fly. A half-row line buffer holds the horizontal pair maxima of even rows, and one pooled sample is emitted per 2×2 window. Output feeds the result writer / next layer at one quarter of the input rate.

---
 rtl/conv_maxpool2.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_maxpool2.sv
// conv_maxpool2: 2x2 stride-2 signed max pooling over a raster sample stream.
// Define CONV_MAXPOOL2_RELU_EN to clamp negative pooled results to zero.
module conv_maxpool2 #(
  parameter int DATA_WIDTH = 32,
  parameter int Q          = 10,
  parameter int W          = 98,
  parameter int H          = 98
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(H + 1);
  localparam int D  = W / 2;
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  // Fixed-point zero in QQ format; also the ReLU floor.
  localparam logic [DATA_WIDTH-1:0] FX_ZERO =
    {DATA_WIDTH{1'b0}} << Q;

  typedef enum logic [1:0] {
    S_EVEN,
    S_ODD,
    S_DROP
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [AW-1:0] idx;

  logic signed [DATA_WIDTH-1:0] prev;
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] pair;
  logic signed [DATA_WIDTH-1:0] held;
  logic signed [DATA_WIDTH-1:0] win;
  logic signed [DATA_WIDTH-1:0] pooled;

  logic [DATA_WIDTH-1:0] lbuf [D];

  logic accept;
  logic last_col;
  logic last_row;
  logic drop_next;
  logic emit;
  logic wr;
  logic busy_r;

  assign accept    = valid_i & ~clr_i;
  assign last_col  = (col == CW'(W - 1));
  assign last_row  = (row == RW'(H - 1));
  assign drop_next = (H % 2 == 1) &&
                     (row == RW'(H - 2));
  assign idx       = AW'(col >> 1);

  assign din  = $signed(data_i);
  assign held = $signed(lbuf[idx]);
  assign pair = (din > prev) ? din : prev;
  assign win  = (held > pair) ? held : pair;

`ifdef CONV_MAXPOOL2_RELU_EN
  assign pooled = win[DATA_WIDTH-1] ? FX_ZERO : win;
`else
  assign pooled = win;
`endif

  assign emit = accept && (state == S_ODD) && col[0];
  assign wr   = accept && (state == S_EVEN) && col[0];

  // Busy drops in the done cycle only if no new frame starts then.
  assign busy_o = busy_r & ~(frame_done_o & ~accept);

  // Next-state: counters advance on accepted samples, FSM at row end.
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    if (accept) begin
      if (last_col) begin
        col_n = '0;
        if (last_row) begin
          row_n   = '0;
          state_n = S_EVEN;
        end else begin
          row_n = row + 1'b1;
          unique case (state)
            S_EVEN:  state_n = S_ODD;
            S_ODD:   state_n = drop_next ? S_DROP
                                         : S_EVEN;
            default: state_n = S_EVEN;
          endcase
        end
      end else begin
        col_n = col + 1'b1;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_EVEN;
      col          <= '0;
      row          <= '0;
      prev         <= '0;
      data_o       <= FX_ZERO;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      busy_r       <= 1'b0;
    end else if (clr_i) begin
      state        <= S_EVEN;
      col          <= '0;
      row          <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state        <= state_n;
      col          <= col_n;
      row          <= row_n;
      valid_o      <= emit;
      frame_done_o <= accept & last_col & last_row;
      if (accept && !col[0])
        prev <= din;
      if (emit)
        data_o <= pooled;
      if (accept)
        busy_r <= 1'b1;
      else if (frame_done_o)
        busy_r <= 1'b0;
    end
  end

  // Half-row buffer of even-row pair maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr)
      lbuf[idx] <= pair;
  end

endmodule
